i2s_tx: RTL and testbench

- I2S master transmitter running in the 27 MHz system clock domain.
- Generates the bit clock (sck) and word select (ws) and serialises one 8-bit parallel sample per frame onto sd, MSB first, in the left (ws low) slot.
- It is the transmit counterpart of the on-chip I2S-to-parallel converter. Typical uses are driving a codec/DAC, or looping back into the converter for self-test.

---
 rtl/i2s_tx_pkg.sv | 13 +
 rtl/i2s_clk_gen.sv | 43 ++++
 rtl/i2s_tx.sv | 60 ++++++
 tb/tb_i2s_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: shared I2S constants and counter-width helper for the transmit and receive paths.
package i2s_tx_pkg;
  localparam int I2S_DATA_W    = 8;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_SCK_DIV   = 10;
  localparam int FRAME_BITS    = 2 * I2S_SLOT_BITS;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bit clock divider and frame bit counter; all frame updates happen on the sck falling edge.
module i2s_clk_gen
  import i2s_tx_pkg::*;
#(
  parameter int SCK_DIV   = I2S_SCK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  localparam int BW       = clog2(2 * SLOT_BITS)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  output logic          sck_o,
  output logic          ws_o,
  output logic          fall_tick,
  output logic          frame_start,
  output logic [BW-1:0] bit_nxt
);
  localparam int HALF = SCK_DIV / 2;
  localparam int FB   = 2 * SLOT_BITS;
  localparam int DW   = clog2(HALF);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic          tick;
  assign tick        = div_cnt == DW'(HALF - 1);
  assign fall_tick   = en_i && tick && sck_o;
  assign frame_start = fall_tick && bit_cnt == BW'(FB - 1);
  assign bit_nxt     = frame_start ? '0 : bit_cnt + 1'b1;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i || !en_i) begin
      div_cnt <= '0;
      bit_cnt <= BW'(FB - 1);
      sck_o   <= 1'b0;
      ws_o    <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) sck_o <= !sck_o;
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        ws_o    <= bit_nxt >= BW'(SLOT_BITS);
      end
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter; one buffered sample per frame, sent MSB first in the left slot.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int SCK_DIV   = I2S_SCK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int DATA_W    = I2S_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_en_i,
  output logic              data_rdy_o,
  output logic              sck_o,
  output logic              ws_o,
  output logic              sd_o,
  output logic              underrun_o,
  output logic              frame_start_o
);
  localparam int BW = clog2(2 * SLOT_BITS);
  logic              fall_tick;
  logic              frame_start;
  logic [BW-1:0]     bit_nxt;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shreg;
  logic              accept;
  logic              send;
  i2s_clk_gen #(.SCK_DIV(SCK_DIV), .SLOT_BITS(SLOT_BITS)) u_clk_gen (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .sck_o      (sck_o),
    .ws_o       (ws_o),
    .fall_tick  (fall_tick),
    .frame_start(frame_start),
    .bit_nxt    (bit_nxt)
  );
  assign accept = data_en_i && data_rdy_o;
  // data bits go out at bit_cnt 1..DATA_W, leaving the one-bit delay after ws falls
  assign send   = fall_tick && bit_nxt != '0 && bit_nxt <= BW'(DATA_W);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold          <= '0;
      shreg         <= '0;
      data_rdy_o    <= 1'b1;
      sd_o          <= 1'b0;
      underrun_o    <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      if (accept) hold <= data_i;
      data_rdy_o    <= !accept && (data_rdy_o || frame_start);
      underrun_o    <= frame_start && data_rdy_o;
      frame_start_o <= frame_start;
      if (frame_start) shreg <= data_rdy_o ? '0 : hold;
      else if (send) shreg <= shreg << 1;
      sd_o <= !en_i ? 1'b0 : fall_tick ? send && shreg[DATA_W-1] : sd_o;
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed stimulus with a per-frame scoreboard; a monitor deserialises sd on sck rising edges.
module tb_i2s_tx;
  typedef struct packed {
    logic       ur;
    logic [7:0] d;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n, en, data_en, data_rdy, sck, ws, sd, underrun, frame_start;
  logic [7:0] data;
  exp_t       exp_q[$];
  int         applied = 0;
  int         miscompares = 0;
  i2s_tx dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en),
    .data_i       (data),
    .data_en_i    (data_en),
    .data_rdy_o   (data_rdy),
    .sck_o        (sck),
    .ws_o         (ws),
    .sd_o         (sd),
    .underrun_o   (underrun),
    .frame_start_o(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int expv);
    applied++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask
  function automatic logic cond(input int sel);
    case (sel)
      0:       return sck;
      1:       return !sck;
      2:       return ws;
      default: return frame_start;
    endcase
  endfunction
  task automatic count_until(input int sel, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!cond(sel) && c < 3000);
  endtask
  task automatic wait_fs(input string nm);
    int c;
    count_until(3, c);
    if (c >= 3000) chk({nm, "_timeout"}, c, 0);
  endtask
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    data = d;
    data_en = 1'b1;
    while (!data_rdy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send_timeout", n, 0);
    @(negedge clk);
    data_en = 1'b0;
  endtask
  // scoreboard monitor: one expectation per frame, popped at frame_start_o
  exp_t       cur;
  logic       active = 1'b0;
  logic       prev_sck = 1'b0;
  logic [7:0] word;
  int         r, stray;
  always @(negedge clk) begin
    if (!rst_n || !en) begin
      active = 1'b0;
      r = 0;
      stray = 0;
    end else begin
      if (underrun && !frame_start) begin
        miscompares++;
        $display("FAIL underrun_no_fs: got 1 expected 0");
      end
      if (frame_start) begin
        if (active) chk("frame_stray_ones", stray, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          chk("frame_underrun", int'(underrun), int'(cur.ur));
        end
        r = 0;
        stray = 0;
        word = '0;
      end
      if (active && sck && !prev_sck) begin
        if (r >= 1 && r <= 8) word = {word[6:0], sd};
        else if (sd) stray++;
        if (r == 8) chk("frame_data", int'(word), int'(cur.d));
        r++;
      end
    end
    prev_sck = sck;
  end
  initial begin
    int c;
    rst_n = 1'b0;
    en = 1'b0;
    data_en = 1'b0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", int'(sck), 0);
    chk("rst_ws", int'(ws), 1);
    chk("rst_sd", int'(sd), 0);
    chk("rst_rdy", int'(data_rdy), 1);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_fs", int'(frame_start), 0);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back('{1'b1, 8'h00});
    exp_q.push_back('{1'b1, 8'h00});
    en = 1'b1;
    count_until(0, c);
    chk("first_rise", c, 5);
    count_until(3, c);
    chk("rise_to_fs", c, 5);
    chk("fs_ws_low", int'(ws), 0);
    count_until(2, c);
    chk("ws_low_len", c, 320);
    count_until(3, c);
    chk("ws_high_len", c, 320);
    exp_q.push_back('{1'b0, 8'hA5});
    count_until(0, c);
    count_until(1, c);
    chk("sck_high", c, 5);
    count_until(0, c);
    chk("sck_low", c, 5);
    chk("rdy_idle", int'(data_rdy), 1);
    data = 8'hA5;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    chk("rdy_after_write", int'(data_rdy), 0);
    wait_fs("fs3");
    chk("rdy_at_fs", int'(data_rdy), 1);
    exp_q.push_back('{1'b0, 8'h01});
    exp_q.push_back('{1'b0, 8'h80});
    send(8'h01);
    send(8'h80);
    chk("rdy_b2b", int'(data_rdy), 0);
    exp_q.push_back('{1'b0, 8'h11});
    wait_fs("fs5");
    send(8'h11);
    data = 8'h22;
    data_en = 1'b1;
    repeat (3) @(negedge clk);
    data_en = 1'b0;
    chk("rdy_full_drop", int'(data_rdy), 0);
    exp_q.push_back('{1'b1, 8'h00});
    exp_q.push_back('{1'b0, 8'h3C});
    wait_fs("fs6");
    repeat (639) @(negedge clk);
    data = 8'h3C;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    chk("coinc_fs", int'(frame_start), 1);
    chk("coinc_underrun", int'(underrun), 1);
    chk("coinc_rdy", int'(data_rdy), 0);
    wait_fs("fs8");
    repeat (36) @(negedge clk);
    chk("pre_abort_sck", int'(sck), 1);
    chk("pre_abort_sd", int'(sd), 1);
    chk("pre_abort_ws", int'(ws), 0);
    en = 1'b0;
    @(negedge clk);
    chk("abort_sck", int'(sck), 0);
    chk("abort_ws", int'(ws), 1);
    chk("abort_sd", int'(sd), 0);
    send(8'h5A);
    repeat (20) @(negedge clk);
    chk("dis_buf_kept", int'(data_rdy), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", int'(data_rdy), 1);
    chk("arst_sck", int'(sck), 0);
    chk("arst_ws", int'(ws), 1);
    chk("arst_sd", int'(sd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back('{1'b1, 8'h00});
    en = 1'b1;
    count_until(0, c);
    chk("re_first_rise", c, 5);
    count_until(3, c);
    chk("re_rise_to_fs", c, 5);
    repeat (120) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
